// File: rtl/demux1_3_reg_if.sv
`default_nettype none
// ============================================================================
//  Module     : demux1_3_reg_if
//  Description: Handshake bundle for the 1-to-3 registered demultiplexer.
//               One input channel (data/select/valid/ready) and three
//               registered output slots with per-slot valid/ready.
//               sel_err exists only when DEMUX1_3_ERR_EN is defined.
//  Revision   : 1.0 - initial release
// ============================================================================
interface demux1_3_reg_if;
   logic [31:0] in_data;
   logic [1:0]  in_sel;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out1_data;
   logic [31:0] out2_data;
   logic [31:0] out3_data;
   logic [2:0]  out_valid;
   logic [2:0]  out_ready;
`ifdef DEMUX1_3_ERR_EN
   logic        sel_err;
`endif

   // Producer + consumers side
   modport master (
      output in_data,
      output in_sel,
      output in_valid,
      input  in_ready,
      input  out1_data,
      input  out2_data,
      input  out3_data,
      input  out_valid,
      output out_ready
`ifdef DEMUX1_3_ERR_EN
      ,
      input  sel_err
`endif
   );

   // Demultiplexer side
   modport slave (
      input  in_data,
      input  in_sel,
      input  in_valid,
      output in_ready,
      output out1_data,
      output out2_data,
      output out3_data,
      output out_valid,
      input  out_ready
`ifdef DEMUX1_3_ERR_EN
      ,
      output sel_err
`endif
   );
endinterface
`default_nettype wire

// File: rtl/demux1_3_reg.sv
`default_nettype none
// ============================================================================
//  Module     : demux1_3_reg
//  Description: 1-to-3 demultiplexer with one registered 32-bit slot per
//               output. in_sel 00 -> out1, 01 -> out2, 10/11 -> out3.
//               Each slot accepts a new word when empty or when its current
//               word is delivered in the same cycle (no bubble).
//               Optional macro DEMUX1_3_ERR_EN: in_sel = 11 is illegal, the
//               word is dropped and a sticky sel_err flag is raised.
//  Revision   : 1.0 - initial release
// ============================================================================
module demux1_3_reg (
   input  wire logic      clk,
   input  wire logic      rst,
   demux1_3_reg_if.slave  bus
);

   localparam int unsigned C_NSLOT = 3;

   logic [2:0]  w_tgt_oh;        // one-hot target slot
   logic        w_illegal;       // select value that must be dropped
   logic        w_slot_busy;     // target slot full and not draining
   logic        w_in_ready;
   logic        w_accept;
   logic [2:0]  w_slot_valid;
   logic [31:0] w_slot_data [C_NSLOT];

   // Decode the select into a one-hot slot target
   always_comb begin
      w_tgt_oh = 3'b000;
      case (bus.in_sel)
         2'b00:   w_tgt_oh = 3'b001;
         2'b01:   w_tgt_oh = 3'b010;
         default: w_tgt_oh = 3'b100;
      endcase
   end

`ifdef DEMUX1_3_ERR_EN
   assign w_illegal = (bus.in_sel == 2'b11);
`else
   assign w_illegal = 1'b0;
`endif

   // A dropped illegal word is always "accepted" so the producer never stalls
   assign w_slot_busy = |(w_tgt_oh & w_slot_valid & ~bus.out_ready);
   assign w_in_ready  = w_illegal | ~w_slot_busy;
   assign w_accept    = bus.in_valid & w_in_ready & ~w_illegal;

   for (genvar k = 0; k < C_NSLOT; k++) begin : g_slot
      logic [31:0] data_q;
      logic [31:0] data_d;
      logic        valid_q;
      logic        valid_d;
      logic        w_load;
      logic        w_deliver;

      assign w_load    = w_accept & w_tgt_oh[k];
      assign w_deliver = valid_q & bus.out_ready[k];

      // Next slot state: a load wins over a delivery so the slot stays full
      always_comb begin
         data_d  = data_q;
         valid_d = valid_q;
         if (w_load) begin
            data_d  = bus.in_data;
            valid_d = 1'b1;
         end else if (w_deliver) begin
            valid_d = 1'b0;
         end
      end

      // Slot register; data is kept after delivery, only reset clears it
      always_ff @(posedge clk) begin
         if (rst) begin
            data_q  <= 32'h0;
            valid_q <= 1'b0;
         end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
         end
      end

      assign w_slot_valid[k] = valid_q;
      assign w_slot_data[k]  = data_q;
   end

`ifdef DEMUX1_3_ERR_EN
   logic sel_err_q;
   logic sel_err_d;

   // Sticky flag: set by any offered illegal select, cleared only by reset
   always_comb begin
      sel_err_d = sel_err_q | (bus.in_valid & w_illegal);
   end

   // Error flag register
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_err_q <= 1'b0;
      end else begin
         sel_err_q <= sel_err_d;
      end
   end

   assign bus.sel_err = sel_err_q;
`endif

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_slot_valid;
   assign bus.out1_data = w_slot_data[0];
   assign bus.out2_data = w_slot_data[1];
   assign bus.out3_data = w_slot_data[2];

endmodule
`default_nettype wire

// File: tb/tb_demux1_3_reg.sv
`default_nettype none
// ============================================================================
//  Module     : tb_demux1_3_reg
//  Description: Directed self-checking bench for demux1_3_reg.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_demux1_3_reg;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   demux1_3_reg_if u_if ();

   demux1_3_reg u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // advance one rising edge and settle outputs
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] sel, input logic [31:0] d,
                        input logic [2:0] ordy);
      u_if.in_valid  = v;
      u_if.in_sel    = sel;
      u_if.in_data   = d;
      u_if.out_ready = ordy;
   endtask

   logic [31:0] words [4];

   initial begin
      total = 0;
      bad   = 0;
      words[0] = 32'hC000_0000;
      words[1] = 32'hC000_0001;
      words[2] = 32'hC000_0002;
      words[3] = 32'hC000_0003;

      // ---------------- reset ----------------
      rst = 1'b1;
      drive(1'b0, 2'b00, 32'h0, 3'b000);
      step();
      step();
      rst = 1'b0;
      check("rst_valid", {29'h0, u_if.out_valid}, 32'h0);
      check("rst_d1", u_if.out1_data, 32'h0);
      check("rst_d2", u_if.out2_data, 32'h0);
      check("rst_d3", u_if.out3_data, 32'h0);
      check("rst_ready", {31'h0, u_if.in_ready}, 32'h1);
`ifdef DEMUX1_3_ERR_EN
      check("rst_selerr", {31'h0, u_if.sel_err}, 32'h0);
`endif

      // ---------------- basic route to out1 ----------------
      drive(1'b1, 2'b00, 32'hDEADBEEF, 3'b000);
      step();
      check("b_d1", u_if.out1_data, 32'hDEADBEEF);
      check("b_valid", {29'h0, u_if.out_valid}, 32'h1);

      // ---------------- slot 2 backpressure ----------------
      drive(1'b1, 2'b01, 32'h0000_00A1, 3'b000);
      step();
      check("bp_fill_d2", u_if.out2_data, 32'h0000_00A1);
      check("bp_fill_valid", {29'h0, u_if.out_valid}, 32'h3);
      drive(1'b1, 2'b01, 32'h0000_00B2, 3'b000);
      #1;
      check("bp_stall_ready", {31'h0, u_if.in_ready}, 32'h0);
      step();
      check("bp_hold_d2", u_if.out2_data, 32'h0000_00A1);
      check("bp_hold_valid", {29'h0, u_if.out_valid}, 32'h3);
      drive(1'b1, 2'b01, 32'h0000_00B2, 3'b010);
      #1;
      check("bp_pass_ready", {31'h0, u_if.in_ready}, 32'h1);
      step();
      check("bp_swap_d2", u_if.out2_data, 32'h0000_00B2);
      check("bp_swap_valid", {29'h0, u_if.out_valid}, 32'h3);
      drive(1'b0, 2'b01, 32'h0000_FFFF, 3'b010);
      step();
      check("bp_drain_valid", {29'h0, u_if.out_valid}, 32'h1);
      check("bp_keep_d2", u_if.out2_data, 32'h0000_00B2);

      // ---------------- slot 1 stalled, slot 3 streams ----------------
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 2'b10, words[i], 3'b100);
         #1;
         check("st_ready", {31'h0, u_if.in_ready}, 32'h1);
         step();
         check("st_d3", u_if.out3_data, words[i]);
         check("st_valid", {29'h0, u_if.out_valid}, 32'h5);
         check("st_d1_hold", u_if.out1_data, 32'hDEADBEEF);
      end
      drive(1'b0, 2'b10, 32'h0, 3'b100);
      step();
      check("st_drain_valid", {29'h0, u_if.out_valid}, 32'h1);

      // ---------------- full-rate round robin ----------------
      drive(1'b1, 2'b00, 32'h1, 3'b111);
      #1;
      check("rr_ready1", {31'h0, u_if.in_ready}, 32'h1);
      step();
      check("rr_d1", u_if.out1_data, 32'h1);
      check("rr_valid1", {29'h0, u_if.out_valid}, 32'h1);
      drive(1'b1, 2'b01, 32'h2, 3'b111);
      #1;
      check("rr_ready2", {31'h0, u_if.in_ready}, 32'h1);
      step();
      check("rr_d2", u_if.out2_data, 32'h2);
      check("rr_valid2", {29'h0, u_if.out_valid}, 32'h2);
      drive(1'b1, 2'b10, 32'h3, 3'b111);
      #1;
      check("rr_ready3", {31'h0, u_if.in_ready}, 32'h1);
      step();
      check("rr_d3", u_if.out3_data, 32'h3);
      check("rr_valid3", {29'h0, u_if.out_valid}, 32'h4);
      drive(1'b0, 2'b00, 32'h0, 3'b111);
      step();
      check("rr_empty", {29'h0, u_if.out_valid}, 32'h0);
      check("rr_d1_kept", u_if.out1_data, 32'h1);

      // ---------------- in_sel = 11 ----------------
      drive(1'b1, 2'b11, 32'h12345678, 3'b000);
      #1;
      check("s11_ready", {31'h0, u_if.in_ready}, 32'h1);
      step();
`ifdef DEMUX1_3_ERR_EN
      check("s11_err", {31'h0, u_if.sel_err}, 32'h1);
      check("s11_valid", {29'h0, u_if.out_valid}, 32'h0);
      check("s11_d3", u_if.out3_data, 32'h3);
      drive(1'b0, 2'b00, 32'h0, 3'b000);
      step();
      check("s11_sticky", {31'h0, u_if.sel_err}, 32'h1);
`else
      check("s11_d3", u_if.out3_data, 32'h12345678);
      check("s11_valid", {29'h0, u_if.out_valid}, 32'h4);
      drive(1'b0, 2'b00, 32'h0, 3'b111);
      step();
      check("s11_drain", {29'h0, u_if.out_valid}, 32'h0);
`endif

      // ---------------- reset with all slots full ----------------
      drive(1'b1, 2'b00, 32'h11, 3'b000);
      step();
      drive(1'b1, 2'b01, 32'h22, 3'b000);
      step();
      drive(1'b1, 2'b10, 32'h33, 3'b000);
      step();
      check("full_valid", {29'h0, u_if.out_valid}, 32'h7);
      check("full_d1", u_if.out1_data, 32'h11);
      check("full_d2", u_if.out2_data, 32'h22);
      check("full_d3", u_if.out3_data, 32'h33);
      rst = 1'b1;
      drive(1'b1, 2'b00, 32'h99, 3'b111);
      step();
      rst = 1'b0;
      drive(1'b0, 2'b00, 32'h0, 3'b000);
      #1;
      check("mr_valid", {29'h0, u_if.out_valid}, 32'h0);
      check("mr_d1", u_if.out1_data, 32'h0);
      check("mr_d2", u_if.out2_data, 32'h0);
      check("mr_d3", u_if.out3_data, 32'h0);
      check("mr_ready", {31'h0, u_if.in_ready}, 32'h1);
`ifdef DEMUX1_3_ERR_EN
      check("mr_selerr", {31'h0, u_if.sel_err}, 32'h0);
`endif

      // idle input must not change state
      step();
      check("idle_valid", {29'h0, u_if.out_valid}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/demux1_3_reg.md
DEMUX1_3_REG -- requirements
Module: demux1_3_reg

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port in_data, input, 32 bits: word to be routed.
REQ-004 SHALL have port in_sel, input, 2 bits: destination select (00 -> out1, 01 -> out2, 10/11 -> out3).
REQ-005 SHALL have port in_valid, input, 1 bit: in_data/in_sel valid this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts the input this cycle.
REQ-007 SHALL have ports out1_data, out2_data, out3_data, output, 32 bits each: registered slot contents.
REQ-008 SHALL have port out_valid, output, 3 bits: bit k-1 set = slot outk holds an undelivered word.
REQ-009 SHALL have port out_ready, input, 3 bits: bit k-1 set = consumer k takes outk this cycle.
REQ-010 SHALL have port sel_err, output, 1 bit, present only under DEMUX1_3_ERR_EN: sticky illegal-select flag.

Function
REQ-011 SHALL hold one 32-bit data register and one valid bit per output slot (3 slots, independent).
REQ-012 SHALL define the target slot T from in_sel as in REQ-004 (except REQ-026).
REQ-013 SHALL drive in_ready combinationally = (slot T empty) OR (slot T valid AND its out_ready high).
REQ-014 SHALL treat in_valid AND in_ready as accept; on accept, slot T data <= in_data and valid <= 1 at next edge (latency 1 cycle).
REQ-015 SHALL treat out_valid[k] AND out_ready[k] as delivery; on delivery without a same-cycle accept into that slot, valid[k] <= 0 next edge.
REQ-016 SHALL, on same-cycle delivery and accept into the same slot, load the new word and keep valid[k] = 1 (no bubble, no loss).
REQ-017 SHALL leave non-target slots unchanged except for their own delivery.
REQ-018 SHALL hold slot data stable while valid and not delivered, regardless of input activity.
REQ-019 SHALL keep outk_data at its last value after delivery (not cleared).
REQ-020 SHALL produce no combinational path from in_data to any outk_data.
REQ-021 SHALL tolerate in_ready being sampled with in_valid low; no state change results.
REQ-022 SHALL accept at most one word per cycle; throughput to a continuously ready slot is one word per cycle.

Reset
REQ-023 SHALL, when rst is high at a rising edge, clear out_valid to 000 and all outk_data to 32'h0, overriding any accept or delivery that cycle.
REQ-024 SHALL drive in_ready = 1 after reset, since all slots are empty.
REQ-025 SHALL, on reset mid-transfer, discard held words with no delivery, and clear sel_err when present.

Configuration
REQ-026 SHALL, with DEMUX1_3_ERR_EN defined, treat in_sel = 11 as illegal: in_ready = 1, word dropped, no slot written, sel_err set next edge and held until rst.
REQ-027 SHALL, without DEMUX1_3_ERR_EN, route in_sel = 11 to out3 identically to 10, and omit sel_err.

Verification
REQ-028 SHALL cover: reset, then in_data = 32'hDEADBEEF with in_sel = 00 and in_valid = 1 -> next cycle out1_data = DEADBEEF, out_valid = 001.
REQ-029 SHALL cover: slot 2 full with out_ready[1] = 0, in_sel = 01 -> in_ready = 0 and out2_data unchanged; raise out_ready[1] -> accept plus delivery in the same cycle, out_valid[1] stays 1 with the new word.
REQ-030 SHALL cover: out_ready = 111, words 1, 2, 3 on in_sel = 00, 01, 10 on consecutive cycles -> each appears one cycle later on out1, out2, out3, no stalls.
REQ-031 SHALL cover: rst asserted with all three slots valid and in_valid = 1 -> next cycle out_valid = 000, all data 0.
REQ-032 SHALL cover: in_sel = 11, data 32'h12345678 -> with macro, sel_err = 1 and out_valid unchanged; without macro, out3_data = 12345678.
REQ-033 SHALL cover: slot 1 stalled, continuous writes to slot 3 -> slot 3 is unaffected and delivers each cycle.
